// File: rtl/led_out_pkg.sv
// rtl/led_out_pkg.sv - shared state encoding and default parameters for the LED output stage
package led_out_pkg;

  localparam int W_DEF             = 4;
  localparam int PWM_BITS_DEF      = 4;
  localparam int PRESCALE_DEF      = 1024;
  localparam int SETTLE_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    HOLD   = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - global PWM dimming generator; brightness is latched only at period wrap
module led_pwm #(
  parameter int PWM_BITS = 4,
  parameter int PRESCALE = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                pwm_on
);

  localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright_q;
  logic                tick;

  assign tick = (prescaler == PS_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      bright_q  <= '1;
    end else begin
      prescaler <= tick ? '0 : prescaler + PS_W'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        // Only take a new duty at the period boundary so no period is truncated
        if (pwm_cnt == '1) begin
          bright_q <= brightness;
        end
      end
    end
  end

  // Full scale is forced on so all-ones has no one-step dark gap per period
  assign pwm_on = (bright_q == '1) || (pwm_cnt < bright_q);

endmodule

// File: rtl/led_out_stage.sv
// rtl/led_out_stage.sv - freezes the RM pattern across partial reconfiguration and drives dimmed LEDs
module led_out_stage
  import led_out_pkg::*;
#(
  parameter int W             = W_DEF,
  parameter int PWM_BITS      = PWM_BITS_DEF,
  parameter int PRESCALE      = PRESCALE_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        rm_led_in,
  input  logic                decouple_req,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                decouple_ack,
  output logic [W-1:0]        pattern_q,
  output logic [W-1:0]        led_out
);

  localparam int               CNT_W         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic             dec_m;
  logic             dec_s;
  state_t           state_q;
  state_t           next_state;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             load_pattern;
  logic             pwm_on;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_m <= 1'b0;
      dec_s <= 1'b0;
    end else begin
      dec_m <= decouple_req;
      dec_s <= dec_m;
    end
  end

  always_comb begin
    next_state   = state_q;
    next_cnt     = settle_cnt;
    load_pattern = 1'b0;
    case (state_q)
      PASS: begin
        if (dec_s) begin
          next_state = HOLD;
        end else begin
          load_pattern = 1'b1;
        end
      end
      HOLD: begin
        if (!dec_s) begin
          next_state = SETTLE;
          next_cnt   = SETTLE_RELOAD;
        end
      end
      SETTLE: begin
        // A new decouple request wins over counter expiry
        if (dec_s) begin
          next_state = HOLD;
        end else if (settle_cnt == '0) begin
          next_state = PASS;
        end else begin
          next_cnt = settle_cnt - CNT_W'(1);
        end
      end
      default: begin
        next_state = SETTLE;
        next_cnt   = SETTLE_RELOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SETTLE;
      settle_cnt   <= SETTLE_RELOAD;
      decouple_ack <= 1'b1;
      pattern_q    <= '0;
      led_out      <= '0;
    end else begin
      state_q      <= next_state;
      settle_cnt   <= next_cnt;
      decouple_ack <= (next_state != PASS);
      if (load_pattern) begin
        pattern_q <= rm_led_in;
      end
      led_out <= pattern_q & {W{pwm_on}};
    end
  end

  led_pwm #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .brightness (brightness),
    .pwm_on     (pwm_on)
  );

endmodule

// File: tb/tb_led_out_stage.sv
// tb/tb_led_out_stage.sv - scoreboard bench for led_out_stage against a behavioural model
module tb_led_out_stage;

  localparam int P = 2;
  localparam int S = 4;

  typedef struct packed {
    logic       ack;
    logic [3:0] patt;
    logic [3:0] led;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rm_led_in = 4'h0;
  logic       decouple_req = 1'b0;
  logic [3:0] brightness = 4'hF;
  logic       decouple_ack;
  logic [3:0] pattern_q;
  logic [3:0] led_out;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Model state: quiet counts consecutive sampled-idle edges since the last decouple (reset counts as one)
  int         m_t;
  int         m_quiet;
  logic       m_dm, m_ds;
  logic [3:0] m_patt;
  logic [3:0] m_bright;

  led_out_stage #(
    .W             (4),
    .PWM_BITS      (4),
    .PRESCALE      (P),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rm_led_in    (rm_led_in),
    .decouple_req (decouple_req),
    .brightness   (brightness),
    .decouple_ack (decouple_ack),
    .pattern_q    (pattern_q),
    .led_out      (led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_t      = 0;
    m_quiet  = 1;
    m_dm     = 1'b0;
    m_ds     = 1'b0;
    m_patt   = 4'h0;
    m_bright = 4'hF;
  endtask

  // Called at a negedge: drive inputs for the coming edge, predict outputs after it, then wait a cycle
  task automatic step(input logic req, input logic [3:0] din, input logic [3:0] br);
    exp_t e;
    int   cnt;
    logic on;
    decouple_req = req;
    rm_led_in    = din;
    brightness   = br;
    cnt   = (m_t / P) % 16;
    on    = (m_bright == 4'hF) || (cnt < int'(m_bright));
    e.led = on ? m_patt : 4'h0;
    if (m_quiet >= S + 1 && !m_ds) m_patt = din;
    e.patt  = m_patt;
    m_quiet = m_ds ? 0 : ((m_quiet < 1000) ? m_quiet + 1 : m_quiet);
    m_ds    = m_dm;
    m_dm    = req;
    if ((m_t + 1) % (16 * P) == 0) m_bright = br;
    m_t++;
    e.ack = (m_quiet < S + 1);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    chk("rst_led_out", int'(led_out), 0);
    chk("rst_pattern_q", int'(pattern_q), 0);
    chk("rst_ack", int'(decouple_ack), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (decouple_ack == e.ack && pattern_q == e.patt && led_out == e.led) n_pass++;
      else $display("FAIL cycle_check t=%0t: ack/pattern/led got %0b/%0h/%0h expected %0b/%0h/%0h",
                    $time, decouple_ack, pattern_q, led_out, e.ack, e.patt, e.led);
    end
  end

  initial begin
    logic       req;
    logic [3:0] br;
    int         len;
    #2;
    reset_pulse();

    // Start-up settle, then pass-through of A
    repeat (10) step(1'b0, 4'hA, 4'hF);
    step(1'b0, 4'h3, 4'hF);
    step(1'b0, 4'h4, 4'hF);
    step(1'b0, 4'h5, 4'hF);
    repeat (4) step(1'b0, 4'($urandom), 4'hF);

    // Decouple with garbage input, release, settle
    repeat (4) step(1'b0, 4'h6, 4'hF);
    repeat (10) step(1'b1, 4'($urandom), 4'hF);
    repeat (12) step(1'b0, 4'($urandom), 4'hF);

    // Re-decouple in the middle of the settle window
    repeat (4) step(1'b0, 4'h6, 4'hF);
    repeat (6) step(1'b1, 4'($urandom), 4'hF);
    repeat (3) step(1'b0, 4'($urandom), 4'hF);
    repeat (6) step(1'b1, 4'($urandom), 4'hF);
    repeat (12) step(1'b0, 4'($urandom), 4'hF);

    // PWM duty: 4/16, off, full, then a mid-period change 2 -> C
    repeat (80) step(1'b0, 4'hF, 4'h4);
    repeat (64) step(1'b0, 4'hF, 4'h0);
    repeat (64) step(1'b0, 4'hF, 4'hF);
    repeat (40) step(1'b0, 4'hF, 4'h2);
    repeat (70) step(1'b0, 4'hF, 4'hC);

    // Randomised runs of decouple, pattern and brightness
    for (int r = 0; r < 40; r++) begin
      req = ($urandom_range(0, 3) == 0);
      br  = 4'($urandom);
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) step(req, 4'($urandom), br);
    end

    // Reset while holding a pattern of 9
    repeat (12) step(1'b0, 4'h9, 4'hF);
    repeat (6) step(1'b1, 4'($urandom), 4'hF);
    reset_pulse();
    repeat (12) step(1'b0, 4'h7, 4'hF);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
